// File: rtl/axi_stream_bridge.sv
// AXI4 slave that stands in for the XDMA BRAM target: W beats feed a TX stream FIFO,
// R beats drain an RX stream FIFO, and reads with addr[12] set return both fill levels.
module axi_stream_bridge #(
  parameter int unsigned AXI_IDWIDTH = 4,
  parameter int unsigned AXI_AWIDTH  = 64,
  parameter int unsigned AXI_DWIDTH  = 64,
  parameter int unsigned FIFO_AWIDTH = 9
) (
  input  logic                      rstn,
  input  logic                      clk,
  // write address
  output logic                      s_axi_awready,
  input  logic                      s_axi_awvalid,
  input  logic [AXI_AWIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                s_axi_awlen,
  input  logic [AXI_IDWIDTH-1:0]    s_axi_awid,
  // write data
  output logic                      s_axi_wready,
  input  logic                      s_axi_wvalid,
  input  logic                      s_axi_wlast,
  input  logic [AXI_DWIDTH-1:0]     s_axi_wdata,
  input  logic [AXI_DWIDTH/8-1:0]   s_axi_wstrb,
  // write response
  input  logic                      s_axi_bready,
  output logic                      s_axi_bvalid,
  output logic [AXI_IDWIDTH-1:0]    s_axi_bid,
  output logic [1:0]                s_axi_bresp,
  // read address
  output logic                      s_axi_arready,
  input  logic                      s_axi_arvalid,
  input  logic [AXI_AWIDTH-1:0]     s_axi_araddr,
  input  logic [7:0]                s_axi_arlen,
  input  logic [AXI_IDWIDTH-1:0]    s_axi_arid,
  // read data
  input  logic                      s_axi_rready,
  output logic                      s_axi_rvalid,
  output logic                      s_axi_rlast,
  output logic [AXI_DWIDTH-1:0]     s_axi_rdata,
  output logic [AXI_IDWIDTH-1:0]    s_axi_rid,
  output logic [1:0]                s_axi_rresp,
  // TX stream to user logic
  input  logic                      m_axis_tready,
  output logic                      m_axis_tvalid,
  output logic [AXI_DWIDTH-1:0]     m_axis_tdata,
  // RX stream from user logic
  output logic                      s_axis_tready,
  input  logic                      s_axis_tvalid,
  input  logic [AXI_DWIDTH-1:0]     s_axis_tdata
);

  localparam int unsigned DEPTH = 1 << FIFO_AWIDTH;
  localparam logic [FIFO_AWIDTH:0]   CNT_ONE = {{FIFO_AWIDTH{1'b0}}, 1'b1};
  localparam logic [FIFO_AWIDTH-1:0] PTR_ONE = {{(FIFO_AWIDTH-1){1'b0}}, 1'b1};

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic       R_IDLE = 1'b0;
  localparam logic       R_DATA = 1'b1;

  // Keeps the address/ready channels closed while rstn is low and releases them one edge later.
  logic run_q;

  logic [1:0]             w_state_q, w_state_d;
  logic [AXI_IDWIDTH-1:0] bid_q, bid_d;
  logic                   r_state_q, r_state_d;
  logic [AXI_IDWIDTH-1:0] rid_q, rid_d;
  logic [7:0]             rlen_q, rlen_d, beat_q, beat_d;
  logic                   rstat_q, rstat_d;

  logic [AXI_DWIDTH-1:0]  tx_mem [DEPTH];
  logic [FIFO_AWIDTH-1:0] tx_wptr_q, tx_rptr_q;
  logic [FIFO_AWIDTH:0]   tx_cnt_q, tx_cnt_d;
  logic                   tx_empty_q, tx_full, tx_push, tx_pop;

  logic [AXI_DWIDTH-1:0]  rx_mem [DEPTH];
  logic [FIFO_AWIDTH-1:0] rx_wptr_q, rx_rptr_q;
  logic [FIFO_AWIDTH:0]   rx_cnt_q, rx_cnt_d;
  logic                   rx_empty_q, rx_full, rx_push, rx_pop;

  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awaddr, s_axi_awlen, s_axi_wstrb, s_axi_araddr};

  // Count never exceeds DEPTH, so the MSB alone marks full.
  assign tx_full = tx_cnt_q[FIFO_AWIDTH];
  assign rx_full = rx_cnt_q[FIFO_AWIDTH];

  always_comb begin
    w_state_d     = w_state_q;
    bid_d         = bid_q;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        s_axi_awready = run_q;
        if (s_axi_awvalid && run_q) begin
          bid_d     = s_axi_awid;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        s_axi_wready = !tx_full;
        if (s_axi_wvalid && !tx_full && s_axi_wlast) w_state_d = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign s_axi_bid   = bid_q;
  assign s_axi_bresp = 2'b00;
  assign tx_push     = s_axi_wvalid && s_axi_wready;

  always_comb begin
    r_state_d     = r_state_q;
    rid_d         = rid_q;
    rlen_d        = rlen_q;
    rstat_d       = rstat_q;
    beat_d        = beat_q;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rlast   = 1'b0;
    if (r_state_q == R_IDLE) begin
      s_axi_arready = run_q;
      if (s_axi_arvalid && run_q) begin
        rid_d     = s_axi_arid;
        rlen_d    = s_axi_arlen;
        rstat_d   = s_axi_araddr[12];
        beat_d    = 8'd0;
        r_state_d = R_DATA;
      end
    end else begin
      s_axi_rvalid = 1'b1;
      s_axi_rlast  = (beat_q == rlen_q);
      if (s_axi_rready) begin
        beat_d = beat_q + 8'd1;
        if (beat_q == rlen_q) r_state_d = R_IDLE;
      end
    end
  end

  assign s_axi_rid   = rid_q;
  assign s_axi_rresp = 2'b00;

  // Data reads never stall: an empty RX FIFO yields zero without popping.
  always_comb begin
    s_axi_rdata = '0;
    if (rstat_q) begin
      s_axi_rdata[15:0]  = 16'(tx_cnt_q);
      s_axi_rdata[31:16] = 16'(rx_cnt_q);
    end else if (!rx_empty_q) begin
      s_axi_rdata = rx_mem[rx_rptr_q];
    end
  end

  assign rx_pop        = s_axi_rvalid && s_axi_rready && !rstat_q && !rx_empty_q;
  assign m_axis_tvalid = !tx_empty_q;
  assign m_axis_tdata  = tx_mem[tx_rptr_q];
  assign tx_pop        = m_axis_tvalid && m_axis_tready;
  assign s_axis_tready = run_q && !rx_full;
  assign rx_push       = s_axis_tvalid && s_axis_tready;

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + CNT_ONE;
    else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CNT_ONE;
    rx_cnt_d = rx_cnt_q;
    if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + CNT_ONE;
    else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q] <= s_axi_wdata;
    if (rx_push) rx_mem[rx_wptr_q] <= s_axis_tdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_q      <= 1'b0;
      w_state_q  <= W_IDLE;
      bid_q      <= '0;
      r_state_q  <= R_IDLE;
      rid_q      <= '0;
      rlen_q     <= '0;
      beat_q     <= '0;
      rstat_q    <= 1'b0;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_cnt_q   <= '0;
      tx_empty_q <= 1'b1;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_cnt_q   <= '0;
      rx_empty_q <= 1'b1;
    end else begin
      run_q     <= 1'b1;
      w_state_q <= w_state_d;
      bid_q     <= bid_d;
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      rlen_q    <= rlen_d;
      beat_q    <= beat_d;
      rstat_q   <= rstat_d;
      if (tx_push) tx_wptr_q <= tx_wptr_q + PTR_ONE;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + PTR_ONE;
      if (rx_push) rx_wptr_q <= rx_wptr_q + PTR_ONE;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + PTR_ONE;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      // Output side sees a new word one edge after the count does; emptying is seen at once.
      tx_empty_q <= (tx_cnt_q == '0) || (tx_cnt_d == '0);
      rx_empty_q <= (rx_cnt_q == '0) || (rx_cnt_d == '0);
    end
  end

endmodule

// File: tb/tb_axi_stream_bridge.sv
// Directed bench for axi_stream_bridge: scoreboard queues for TX stream, R beats and B responses.
module tb_axi_stream_bridge;

  localparam int unsigned IDW   = 4;
  localparam int unsigned AW    = 64;
  localparam int unsigned DW    = 64;
  localparam int unsigned FAW   = 9;
  localparam int          DEPTH = 1 << FAW;
  localparam int          TMO   = 4000;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic           s_axi_awready, s_axi_awvalid;
  logic [AW-1:0]  s_axi_awaddr;
  logic [7:0]     s_axi_awlen;
  logic [IDW-1:0] s_axi_awid;
  logic           s_axi_wready, s_axi_wvalid, s_axi_wlast;
  logic [DW-1:0]  s_axi_wdata;
  logic [DW/8-1:0] s_axi_wstrb;
  logic           s_axi_bready, s_axi_bvalid;
  logic [IDW-1:0] s_axi_bid;
  logic [1:0]     s_axi_bresp;
  logic           s_axi_arready, s_axi_arvalid;
  logic [AW-1:0]  s_axi_araddr;
  logic [7:0]     s_axi_arlen;
  logic [IDW-1:0] s_axi_arid;
  logic           s_axi_rready, s_axi_rvalid, s_axi_rlast;
  logic [DW-1:0]  s_axi_rdata;
  logic [IDW-1:0] s_axi_rid;
  logic [1:0]     s_axi_rresp;
  logic           m_axis_tready, m_axis_tvalid;
  logic [DW-1:0]  m_axis_tdata;
  logic           s_axis_tready, s_axis_tvalid;
  logic [DW-1:0]  s_axis_tdata;

  axi_stream_bridge #(
    .AXI_IDWIDTH(IDW), .AXI_AWIDTH(AW), .AXI_DWIDTH(DW), .FIFO_AWIDTH(FAW)
  ) dut (
    .rstn(rstn), .clk(clk),
    .s_axi_awready(s_axi_awready), .s_axi_awvalid(s_axi_awvalid), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awlen(s_axi_awlen), .s_axi_awid(s_axi_awid),
    .s_axi_wready(s_axi_wready), .s_axi_wvalid(s_axi_wvalid), .s_axi_wlast(s_axi_wlast),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_bready(s_axi_bready), .s_axi_bvalid(s_axi_bvalid), .s_axi_bid(s_axi_bid),
    .s_axi_bresp(s_axi_bresp),
    .s_axi_arready(s_axi_arready), .s_axi_arvalid(s_axi_arvalid), .s_axi_araddr(s_axi_araddr),
    .s_axi_arlen(s_axi_arlen), .s_axi_arid(s_axi_arid),
    .s_axi_rready(s_axi_rready), .s_axi_rvalid(s_axi_rvalid), .s_axi_rlast(s_axi_rlast),
    .s_axi_rdata(s_axi_rdata), .s_axi_rid(s_axi_rid), .s_axi_rresp(s_axi_rresp),
    .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .s_axis_tready(s_axis_tready), .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata)
  );

  typedef struct {
    logic [DW-1:0]  data;
    logic           last;
    logic [IDW-1:0] id;
  } rbeat_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wpushes = 0;
  int w_first_cyc = 0;
  int tv_first_cyc = -1;
  bit tv_arm = 1'b0;
  bit rand_en = 1'b0;

  logic [DW-1:0]  tx_q[$];
  logic [DW-1:0]  rx_q[$];
  logic [DW-1:0]  wlist[$];
  rbeat_t         r_q[$];
  logic [IDW-1:0] b_q[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    forever begin
      @(posedge clk);
      cyc++;
    end
  endtask

  task automatic rnd_loop();
    forever begin
      @(posedge clk);
      #1;
      if (rand_en) {m_axis_tready, s_axi_rready, s_axi_bready} = 3'($urandom_range(0, 7));
    end
  endtask

  // Handshakes seen at a negedge complete on the following posedge.
  task automatic mon_loop();
    rbeat_t e;
    logic [IDW-1:0] eb;
    forever begin
      @(negedge clk);
      if (tv_arm && m_axis_tvalid) begin
        tv_first_cyc = cyc;
        tv_arm = 1'b0;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (tx_q.size() == 0) chk("tx_extra", 64'(m_axis_tvalid), 64'd0);
        else chk("tx_data", m_axis_tdata, tx_q.pop_front());
      end
      if (s_axi_rvalid && s_axi_rready) begin
        if (r_q.size() == 0) chk("r_extra", 64'(s_axi_rvalid), 64'd0);
        else begin
          e = r_q.pop_front();
          chk("r_data", s_axi_rdata, e.data);
          chk("r_last", 64'(s_axi_rlast), 64'(e.last));
          chk("r_id", 64'(s_axi_rid), 64'(e.id));
          chk("r_resp", 64'(s_axi_rresp), 64'd0);
        end
      end
      if (s_axi_bvalid && s_axi_bready) begin
        if (b_q.size() == 0) chk("b_extra", 64'(s_axi_bvalid), 64'd0);
        else begin
          eb = b_q.pop_front();
          chk("b_id", 64'(s_axi_bid), 64'(eb));
          chk("b_resp", 64'(s_axi_bresp), 64'd0);
        end
      end
    end
  endtask

  task automatic aw_hs(input logic [IDW-1:0] id, input int beats);
    int g = 0;
    s_axi_awvalid = 1'b1;
    s_axi_awid    = id;
    s_axi_awlen   = 8'(beats - 1);
    s_axi_awaddr  = 64'($urandom);
    @(negedge clk);
    while (!s_axi_awready && g < TMO) begin
      @(negedge clk);
      g++;
    end
    if (g >= TMO) chk("aw_timeout", 64'(s_axi_awready), 64'd1);
    @(posedge clk);
    #1;
    s_axi_awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [DW-1:0] d, input bit last, input bit track);
    int g = 0;
    s_axi_wvalid = 1'b1;
    s_axi_wdata  = d;
    s_axi_wlast  = last;
    s_axi_wstrb  = 8'($urandom);
    @(negedge clk);
    while (!s_axi_wready && g < TMO) begin
      @(negedge clk);
      g++;
    end
    if (g >= TMO) chk("w_timeout", 64'(s_axi_wready), 64'd1);
    else if (track) begin
      tx_q.push_back(d);
      if (wpushes == 0) w_first_cyc = cyc;
      wpushes++;
    end
    @(posedge clk);
    #1;
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
  endtask

  task automatic axi_write(input logic [IDW-1:0] id);
    int n = wlist.size();
    wpushes = 0;
    b_q.push_back(id);
    aw_hs(id, n);
    for (int i = 0; i < n; i++) w_beat(wlist[i], i == n - 1, 1'b1);
  endtask

  task automatic axi_read(input logic [IDW-1:0] id, input int len, input bit status,
                          input logic [DW-1:0] status_exp);
    int g = 0;
    logic [AW-1:0] a;
    rbeat_t e;
    a = 64'($urandom);
    a[12] = status;
    s_axi_arvalid = 1'b1;
    s_axi_arid    = id;
    s_axi_arlen   = 8'(len);
    s_axi_araddr  = a;
    @(negedge clk);
    while (!s_axi_arready && g < TMO) begin
      @(negedge clk);
      g++;
    end
    if (g >= TMO) chk("ar_timeout", 64'(s_axi_arready), 64'd1);
    for (int i = 0; i <= len; i++) begin
      if (status) e.data = status_exp;
      else e.data = (rx_q.size() != 0) ? rx_q.pop_front() : '0;
      e.last = (i == len);
      e.id   = id;
      r_q.push_back(e);
    end
    @(posedge clk);
    #1;
    s_axi_arvalid = 1'b0;
    g = 0;
    while (r_q.size() != 0 && g < TMO) begin
      @(negedge clk);
      g++;
    end
    if (g >= TMO) begin
      chk("r_timeout", 64'(r_q.size()), 64'd0);
      r_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic axis_push(input logic [DW-1:0] d);
    int g = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    @(negedge clk);
    while (!s_axis_tready && g < TMO) begin
      @(negedge clk);
      g++;
    end
    if (g >= TMO) chk("axis_timeout", 64'(s_axis_tready), 64'd1);
    else rx_q.push_back(d);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((tx_q.size() + r_q.size() + b_q.size()) != 0 && g < TMO) begin
      @(negedge clk);
      g++;
    end
    if (g >= TMO) begin
      chk("drain_tx", 64'(tx_q.size()), 64'd0);
      chk("drain_b", 64'(b_q.size()), 64'd0);
      tx_q.delete();
      b_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awid = '0;
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_bready = 1'b0; s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arlen = '0;
    s_axi_arid = '0; s_axi_rready = 1'b0; m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0;
    fork
      tick();
      mon_loop();
      rnd_loop();
    join_none
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 64'(s_axi_awready), 64'd0);
    chk("rst_arready", 64'(s_axi_arready), 64'd0);
    chk("rst_wready", 64'(s_axi_wready), 64'd0);
    chk("rst_axis_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
    chk("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    chk("rst_rlast", 64'(s_axi_rlast), 64'd0);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_awready", 64'(s_axi_awready), 64'd1);
    chk("rel_arready", 64'(s_axi_arready), 64'd1);
    chk("rel_axis_tready", 64'(s_axis_tready), 64'd1);
    chk("rel_wready", 64'(s_axi_wready), 64'd0);

    // Four-beat burst; awlen=3 and stream order/latency checked.
    m_axis_tready = 1'b1; s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    wlist = '{64'h11, 64'h22, 64'h33, 64'h44};
    tv_arm = 1'b1;
    axi_write(4'h3);
    drain();
    chk("tx_latency", 64'(tv_first_cyc - w_first_cyc), 64'd2);

    // Fill TX to full with the stream stalled, then release.
    m_axis_tready = 1'b0;
    wlist.delete();
    for (int i = 0; i <= DEPTH; i++) wlist.push_back(64'hA000 + 64'(i));
    fork
      axi_write(4'h7);
      begin
        int g = 0;
        while (wpushes < DEPTH && g < TMO) begin
          @(posedge clk);
          g++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("full_wready", 64'(s_axi_wready), 64'd0);
        axi_read(4'h2, 0, 1'b1, 64'(DEPTH));
        m_axis_tready = 1'b1;
      end
    join
    drain();

    // Non-blocking data read past the end of the RX contents.
    axis_push(64'hA);
    axis_push(64'hB);
    repeat (2) @(posedge clk);
    #1;
    axi_read(4'h5, 3, 1'b0, '0);
    axi_read(4'h6, 0, 1'b1, 64'h0);

    // Concurrent 16-beat write and read under random back-pressure.
    for (int i = 0; i < 16; i++) axis_push(64'hB00 + 64'(i));
    repeat (3) @(posedge clk);
    #1;
    wlist.delete();
    for (int i = 0; i < 16; i++) wlist.push_back(64'hC00 + 64'(i));
    rand_en = 1'b1;
    fork
      axi_write(4'hA);
      axi_read(4'hB, 15, 1'b0, '0);
    join
    drain();
    rand_en = 1'b0;
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1; s_axi_rready = 1'b1; s_axi_bready = 1'b1;
    axi_read(4'h1, 0, 1'b1, 64'h0);

    // Reset in the middle of an 8-beat burst: burst abandoned, FIFOs flushed.
    m_axis_tready = 1'b0;
    aw_hs(4'hE, 8);
    w_beat(64'hD0, 1'b0, 1'b0);
    w_beat(64'hD1, 1'b0, 1'b0);
    rstn = 1'b0;
    #1;
    chk("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("mid_rst_bvalid", 64'(s_axi_bvalid), 64'd0);
    chk("mid_rst_wready", 64'(s_axi_wready), 64'd0);
    chk("mid_rst_awready", 64'(s_axi_awready), 64'd0);
    chk("mid_rst_axis_tready", 64'(s_axis_tready), 64'd0);
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    chk("rel2_awready", 64'(s_axi_awready), 64'd1);
    chk("rel2_tvalid", 64'(m_axis_tvalid), 64'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("rel2_bvalid", 64'(s_axi_bvalid), 64'd0);
    axi_read(4'h4, 0, 1'b1, 64'h0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
